// File: rtl/nasti_mem_tester_pkg.sv
// Shared types and constants for the NASTI memory tester.
// Includes the state enum, NASTI response/burst codes and the data pattern generator.
package nasti_tester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AW,
        W,
        B,
        AR,
        R,
        DONE
    } state_e;

    localparam logic [1:0] NASTI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] NASTI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] NASTI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] NASTI_RESP_DECERR = 2'b11;

    localparam logic [1:0] NASTI_BURST_INCR  = 2'b01;

    // 32-bit lane value of a beat at byte address addr
    function automatic logic [31:0] pattern(input logic [63:0] addr,
                                            input logic [7:0]  lane,
                                            input logic [31:0] seed);
        logic [63:0] a;
        a = addr + {54'd0, lane, 2'b00};
        return a[31:0] ^ seed;
    endfunction

endpackage

// File: rtl/nasti_mem_tester_if.sv
// NASTI AW/W/B/AR/R channel bundle with master and slave views.
interface nasti_channel #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1
);
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;

    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;

    logic                    b_valid;
    logic                    b_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;

    logic                    ar_valid;
    logic                    ar_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;

    logic                    r_valid;
    logic                    r_ready;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last, w_user,
        input  w_ready,
        input  b_valid, b_id, b_resp, b_user,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last, r_user,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last, w_user,
        output w_ready,
        output b_valid, b_id, b_resp, b_user,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last, r_user,
        input  r_ready
    );

endinterface

// File: rtl/nasti_mem_tester.sv
// NASTI master traffic generator/checker: writes address-derived bursts, reads them
// back and counts data/response/framing errors, with a per-handshake watchdog.
module nasti_mem_tester
    import nasti_tester_pkg::*;
#(
    parameter int                    ID_WIDTH   = 1,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 128,
    parameter int                    USER_WIDTH = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1000,
    parameter int                    BURST_LEN  = 4,
    parameter int                    NUM_BURSTS = 2,
    parameter logic [31:0]           SEED       = 32'hA5A5_5A5A,
    parameter int                    TIMEOUT    = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         timeout,
    output logic [15:0]  err_count,
    nasti_channel.master nasti
);

    localparam int                    BYTES      = DATA_WIDTH / 8;
    localparam int                    LANES      = DATA_WIDTH / 32;
    localparam logic [ADDR_WIDTH-1:0] BEAT_INC   = ADDR_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] BURST_INC  = ADDR_WIDTH'(BURST_LEN * BYTES);
    localparam logic [2:0]            AX_SIZE    = 3'($clog2(BYTES));
    localparam logic [7:0]            AX_LEN     = 8'(BURST_LEN - 1);
    localparam logic [8:0]            LAST_BEAT  = 9'(BURST_LEN - 1);
    localparam int                    WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]       WD_LOAD    = WD_W'(TIMEOUT - 1);
    localparam int                    BURST_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BURST_W-1:0]    LAST_BURST = BURST_W'(NUM_BURSTS - 1);

    state_e                  state_q;
    logic                    busy_q, done_q, timeout_q;
    logic [15:0]             err_q;
    logic                    aw_valid_q, ar_valid_q, w_valid_q, w_last_q;
    logic                    b_ready_q, r_ready_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [ADDR_WIDTH-1:0]   burst_addr_q, addr_q;
    logic [8:0]              beat_q;
    logic [BURST_W-1:0]      burst_q;
    logic [WD_W-1:0]         wd_q;

    logic [ADDR_WIDTH-1:0]   next_addr_d;
    logic [DATA_WIDTH-1:0]   cur_data_d, next_data_d;
    logic                    hs_d, active_d, wd_expired_d, r_bad_d, b_bad_d;
    logic                    unused_user;

    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) begin
            d[32*i +: 32] = pattern(64'(a), 8'(i), SEED);
        end
        return d;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] e);
        return (e == 16'hFFFF) ? e : e + 16'd1;
    endfunction

    always_comb begin
        next_addr_d  = addr_q + BEAT_INC;
        cur_data_d   = beat_data(addr_q);
        next_data_d  = beat_data(next_addr_d);
        active_d     = state_q inside {AW, W, B, AR, R};
        hs_d         = ((state_q == AW) && aw_valid_q && nasti.aw_ready) ||
                       ((state_q == W)  && w_valid_q  && nasti.w_ready)  ||
                       ((state_q == B)  && b_ready_q  && nasti.b_valid)  ||
                       ((state_q == AR) && ar_valid_q && nasti.ar_ready) ||
                       ((state_q == R)  && r_ready_q  && nasti.r_valid);
        wd_expired_d = active_d && (wd_q == '0) && !hs_d;
        b_bad_d      = (nasti.b_resp != NASTI_RESP_OKAY) || (nasti.b_id != {ID_WIDTH{1'b0}});
        // One error per failing beat, whichever fields are wrong
        r_bad_d      = (nasti.r_data != cur_data_d) ||
                       (nasti.r_resp != NASTI_RESP_OKAY) ||
                       (nasti.r_id != {ID_WIDTH{1'b0}}) ||
                       (nasti.r_last != (beat_q == LAST_BEAT)) ||
                       (beat_q > LAST_BEAT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            err_q        <= '0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            w_last_q     <= 1'b0;
            w_data_q     <= '0;
            b_ready_q    <= 1'b0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            burst_addr_q <= '0;
            addr_q       <= '0;
            beat_q       <= '0;
            burst_q      <= '0;
            wd_q         <= WD_LOAD;
        end else begin
            if (active_d) begin
                wd_q <= hs_d ? WD_LOAD : wd_q - 1'b1;
            end
            if (wd_expired_d) begin
                timeout_q  <= 1'b1;
                aw_valid_q <= 1'b0;
                w_valid_q  <= 1'b0;
                w_last_q   <= 1'b0;
                b_ready_q  <= 1'b0;
                ar_valid_q <= 1'b0;
                r_ready_q  <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                state_q    <= DONE;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                        err_q        <= '0;
                        burst_q      <= '0;
                        burst_addr_q <= BASE_ADDR;
                        addr_q       <= BASE_ADDR;
                        aw_valid_q   <= 1'b1;
                        wd_q         <= WD_LOAD;
                        state_q      <= AW;
                    end
                    AW: if (hs_d) begin
                        aw_valid_q <= 1'b0;
                        w_valid_q  <= 1'b1;
                        w_data_q   <= cur_data_d;
                        w_last_q   <= (LAST_BEAT == 9'd0);
                        beat_q     <= '0;
                        state_q    <= W;
                    end
                    W: if (hs_d) begin
                        if (w_last_q) begin
                            w_valid_q <= 1'b0;
                            w_last_q  <= 1'b0;
                            b_ready_q <= 1'b1;
                            state_q   <= B;
                        end else begin
                            beat_q   <= beat_q + 9'd1;
                            addr_q   <= next_addr_d;
                            w_data_q <= next_data_d;
                            w_last_q <= ((beat_q + 9'd1) == LAST_BEAT);
                        end
                    end
                    B: if (hs_d) begin
                        b_ready_q <= 1'b0;
                        if (b_bad_d) err_q <= sat_inc(err_q);
                        if (burst_q == LAST_BURST) begin
                            burst_q      <= '0;
                            burst_addr_q <= BASE_ADDR;
                            addr_q       <= BASE_ADDR;
                            ar_valid_q   <= 1'b1;
                            state_q      <= AR;
                        end else begin
                            burst_q      <= burst_q + BURST_W'(1);
                            burst_addr_q <= burst_addr_q + BURST_INC;
                            addr_q       <= burst_addr_q + BURST_INC;
                            aw_valid_q   <= 1'b1;
                            state_q      <= AW;
                        end
                    end
                    AR: if (hs_d) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        beat_q     <= '0;
                        state_q    <= R;
                    end
                    R: if (hs_d) begin
                        if (r_bad_d) err_q <= sat_inc(err_q);
                        addr_q <= next_addr_d;
                        if (beat_q != 9'h1FF) beat_q <= beat_q + 9'd1;
                        // Burst framing follows the slave's r_last, even when early or late
                        if (nasti.r_last) begin
                            r_ready_q <= 1'b0;
                            if (burst_q == LAST_BURST) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                burst_q      <= burst_q + BURST_W'(1);
                                burst_addr_q <= burst_addr_q + BURST_INC;
                                addr_q       <= burst_addr_q + BURST_INC;
                                ar_valid_q   <= 1'b1;
                                state_q      <= AR;
                            end
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign err_count = err_q;
    assign pass      = done_q && (err_q == 16'd0) && !timeout_q;

    assign nasti.aw_valid  = aw_valid_q;
    assign nasti.aw_id     = {ID_WIDTH{1'b0}};
    assign nasti.aw_addr   = burst_addr_q;
    assign nasti.aw_len    = AX_LEN;
    assign nasti.aw_size   = AX_SIZE;
    assign nasti.aw_burst  = NASTI_BURST_INCR;
    assign nasti.aw_lock   = 1'b0;
    assign nasti.aw_cache  = 4'd0;
    assign nasti.aw_prot   = 3'd0;
    assign nasti.aw_qos    = 4'd0;
    assign nasti.aw_region = 4'd0;
    assign nasti.aw_user   = {USER_WIDTH{1'b0}};

    assign nasti.w_valid   = w_valid_q;
    assign nasti.w_data    = w_data_q;
    assign nasti.w_strb    = '1;
    assign nasti.w_last    = w_last_q;
    assign nasti.w_user    = {USER_WIDTH{1'b0}};

    assign nasti.b_ready   = b_ready_q;

    assign nasti.ar_valid  = ar_valid_q;
    assign nasti.ar_id     = {ID_WIDTH{1'b0}};
    assign nasti.ar_addr   = burst_addr_q;
    assign nasti.ar_len    = AX_LEN;
    assign nasti.ar_size   = AX_SIZE;
    assign nasti.ar_burst  = NASTI_BURST_INCR;
    assign nasti.ar_lock   = 1'b0;
    assign nasti.ar_cache  = 4'd0;
    assign nasti.ar_prot   = 3'd0;
    assign nasti.ar_qos    = 4'd0;
    assign nasti.ar_region = 4'd0;
    assign nasti.ar_user   = {USER_WIDTH{1'b0}};

    assign nasti.r_ready   = r_ready_q;

    assign unused_user = ^{nasti.b_user, nasti.r_user};

endmodule
